nn_sample_tx: RTL

Transmit-side feeder for the neural-network controller's sample-load port. Accepts 32-bit samples from an upstream valid/ready source, buffers them in a small FIFO, and drives the `input_signal`/`in` strobe protocol that the controller's load phase consumes. One frame is FRAME_LEN words. The controller stores one word per complete high/low strobe cycle and leaves its load phase after FRAME_LEN words.

---
 rtl/nn_sample_tx_if.sv | 25 ++
 rtl/nn_sample_tx.sv | 137 +++++++++++++
 2 files changed

// File: rtl/nn_sample_tx_if.sv
// Sample-load bundle: upstream valid/ready sample stream plus the strobe/data pair
// that feeds the controller's load port.
interface nn_sample_tx_if;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_ready;
  logic        tx_signal;
  logic [31:0] tx_data;

  modport master (
    output s_valid,
    output s_data,
    input  s_ready,
    input  tx_signal,
    input  tx_data
  );

  modport slave (
    input  s_valid,
    input  s_data,
    output s_ready,
    output tx_signal,
    output tx_data
  );
endinterface

// File: rtl/nn_sample_tx.sv
// Transmit-side feeder: buffers upstream samples in a small FIFO and replays them as
// high/low strobe cycles for one frame of FRAME_LEN words.
module nn_sample_tx #(
  parameter int unsigned FRAME_LEN   = 1000,
  parameter int unsigned HIGH_CYCLES = 2,
  parameter int unsigned LOW_CYCLES  = 2,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  nn_sample_tx_if.slave bus,
  output logic          busy,
  output logic          done,
  output logic [10:0]   word_cnt
);

  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = AW + 1;
  localparam int unsigned PhMax = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
  localparam int unsigned PhW   = $clog2(PhMax + 1);

  typedef enum logic [2:0] {StIdle, StArm, StHigh, StLow, StDone} state_e;

  state_e          state_q;
  logic [PhW-1:0]  ph_cnt_q;
  logic            tx_signal_q;
  logic [31:0]     tx_data_q;
  logic            busy_q;
  logic            done_q;
  logic [10:0]     word_cnt_q;

  logic [31:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            fifo_full;
  logic            fifo_empty;
  logic            push;
  logic            pop;

  assign fifo_full  = (count_q == CntW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign push       = bus.s_valid && !fifo_full;
  // Pop only from the ARM decision; a word written this cycle is not yet counted,
  // so there is no same-cycle fall-through.
  assign pop        = (state_q == StArm) && !fifo_empty;

  assign bus.s_ready   = !fifo_full;
  assign bus.tx_signal = tx_signal_q;
  assign bus.tx_data   = tx_data_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign word_cnt      = word_cnt_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.s_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !push) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      ph_cnt_q    <= '0;
      tx_signal_q <= 1'b0;
      tx_data_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      word_cnt_q  <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            word_cnt_q <= '0;
            busy_q     <= 1'b1;
            state_q    <= StArm;
          end
        end
        StArm: begin
          // Empty FIFO stalls here with the strobe low, stretching only the low phase.
          if (pop) begin
            tx_data_q   <= mem_q[rd_ptr_q];
            tx_signal_q <= 1'b1;
            ph_cnt_q    <= '0;
            state_q     <= StHigh;
          end
        end
        StHigh: begin
          if (ph_cnt_q == PhW'(HIGH_CYCLES - 1)) begin
            tx_signal_q <= 1'b0;
            word_cnt_q  <= word_cnt_q + 11'd1;
            ph_cnt_q    <= '0;
            state_q     <= StLow;
          end else begin
            ph_cnt_q <= ph_cnt_q + 1'b1;
          end
        end
        StLow: begin
          if (ph_cnt_q == PhW'(LOW_CYCLES - 1)) begin
            state_q <= (word_cnt_q == 11'(FRAME_LEN)) ? StDone : StArm;
          end else begin
            ph_cnt_q <= ph_cnt_q + 1'b1;
          end
        end
        StDone: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
